// File: rtl/cpu_io_bridge_pkg.sv
// rtl/cpu_io_bridge_pkg.sv - shared word width and FIFO sizing for the CPU I/O bridge
package cpu_io_bridge_pkg;

    localparam int CPU_DATA_W    = 10;
    localparam int IO_FIFO_DEPTH = 4;
    localparam int IO_FIFO_PTR_W = $clog2(IO_FIFO_DEPTH);

endpackage

// File: rtl/cpu_io_bridge_fifo.sv
// rtl/cpu_io_bridge_fifo.sv - first-word-fall-through FIFO used for both bridge directions
module io_fifo
    import cpu_io_bridge_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int DEPTH  = IO_FIFO_DEPTH,
    parameter int PTR_W  = IO_FIFO_PTR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full,
    output logic              drop
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    // A pop on an empty FIFO is ignored; a pop frees a slot for a same-cycle push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    // Head is forced to zero when empty so stale storage never leaks out.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care while the count says empty.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/cpu_io_bridge.sv
// rtl/cpu_io_bridge.sv - CPU dataout/datain to device valid/ready bridge with TX and RX FIFOs
module cpu_io_bridge
    import cpu_io_bridge_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int DEPTH  = IO_FIFO_DEPTH,
    parameter int PTR_W  = IO_FIFO_PTR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] cpu_dataout,
    input  logic              cpu_out_we,
    output logic              cpu_out_full,
    output logic [DATA_W-1:0] cpu_datain,
    output logic              cpu_in_avail,
    input  logic              cpu_in_re,
    output logic [DATA_W-1:0] dev_tx_data,
    output logic              dev_tx_valid,
    input  logic              dev_tx_ready,
    input  logic [DATA_W-1:0] dev_rx_data,
    input  logic              dev_rx_valid,
    output logic              dev_rx_ready,
    input  logic              clr_flags,
    output logic              ovf_sticky,
    output logic              udf_sticky
);

    logic tx_empty;
    logic tx_drop;
    logic rx_empty;
    logic rx_full;
    logic rx_push;
    logic rx_drop;
    logic ovf_set;
    logic udf_set;

    io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) tx_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (cpu_out_we),
        .pop     (dev_tx_ready),
        .wdata   (cpu_dataout),
        .rdata   (dev_tx_data),
        .empty   (tx_empty),
        .full    (cpu_out_full),
        .drop    (tx_drop)
    );

    // The device only transfers while ready is high, so RX pushes are qualified by it.
    assign dev_rx_ready = !rx_full;
    assign rx_push      = dev_rx_valid && dev_rx_ready;

    io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) rx_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (rx_push),
        .pop     (cpu_in_re),
        .wdata   (dev_rx_data),
        .rdata   (cpu_datain),
        .empty   (rx_empty),
        .full    (rx_full),
        .drop    (rx_drop)
    );

    assign dev_tx_valid = !tx_empty;
    assign cpu_in_avail = !rx_empty;
    assign ovf_set      = tx_drop || rx_drop;
    assign udf_set      = cpu_in_re && rx_empty;

    // Sticky error flags; a clear in the same cycle as a new event wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
        end else if (clr_flags) begin
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
        end else begin
            if (ovf_set) ovf_sticky <= 1'b1;
            if (udf_set) udf_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_io_bridge.sv
// tb/tb_cpu_io_bridge.sv - scoreboard testbench for cpu_io_bridge
module tb_cpu_io_bridge;
    import cpu_io_bridge_pkg::*;

    localparam int W = CPU_DATA_W;
    localparam int D = IO_FIFO_DEPTH;

    logic         clock;
    logic         reset_n;
    logic [W-1:0] cpu_dataout;
    logic         cpu_out_we;
    logic         cpu_out_full;
    logic [W-1:0] cpu_datain;
    logic         cpu_in_avail;
    logic         cpu_in_re;
    logic [W-1:0] dev_tx_data;
    logic         dev_tx_valid;
    logic         dev_tx_ready;
    logic [W-1:0] dev_rx_data;
    logic         dev_rx_valid;
    logic         dev_rx_ready;
    logic         clr_flags;
    logic         ovf_sticky;
    logic         udf_sticky;

    int checks = 0;
    int fails  = 0;
    logic [W-1:0] tx_q[$];
    logic [W-1:0] rx_q[$];
    logic [W-1:0] exp_w;

    cpu_io_bridge #(.DATA_W(W), .DEPTH(D), .PTR_W(IO_FIFO_PTR_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cpu_dataout  (cpu_dataout),
        .cpu_out_we   (cpu_out_we),
        .cpu_out_full (cpu_out_full),
        .cpu_datain   (cpu_datain),
        .cpu_in_avail (cpu_in_avail),
        .cpu_in_re    (cpu_in_re),
        .dev_tx_data  (dev_tx_data),
        .dev_tx_valid (dev_tx_valid),
        .dev_tx_ready (dev_tx_ready),
        .dev_rx_data  (dev_rx_data),
        .dev_rx_valid (dev_rx_valid),
        .dev_rx_ready (dev_rx_ready),
        .clr_flags    (clr_flags),
        .ovf_sticky   (ovf_sticky),
        .udf_sticky   (udf_sticky)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_dataout  = '0;
        cpu_out_we   = 1'b0;
        cpu_in_re    = 1'b0;
        dev_tx_ready = 1'b0;
        dev_rx_data  = '0;
        dev_rx_valid = 1'b0;
        clr_flags    = 1'b0;
    endtask

    task automatic write_tx(input logic [W-1:0] d, input bit expect_accept);
        cpu_dataout = d;
        cpu_out_we  = 1'b1;
        if (expect_accept) tx_q.push_back(d);
        cyc();
        cpu_out_we  = 1'b0;
    endtask

    task automatic send_rx(input logic [W-1:0] d);
        dev_rx_data  = d;
        dev_rx_valid = 1'b1;
        rx_q.push_back(d);
        cyc();
        dev_rx_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
    endtask

    // Drain TX with ready held high, comparing each transfer against the queue.
    task automatic drain_tx(input string name);
        dev_tx_ready = 1'b1;
        for (int i = 0; i < 4 * D + 4; i++) begin
            if (dev_tx_valid) begin
                checks++;
                if (tx_q.size() == 0) begin
                    fails++;
                    $display("FAIL %s_extra: got word %0d, expected no word", name, dev_tx_data);
                end else begin
                    exp_w = tx_q.pop_front();
                    if (dev_tx_data !== exp_w) begin
                        fails++;
                        $display("FAIL %s_data: got %0d expected %0d", name, dev_tx_data, exp_w);
                    end
                end
            end else if (tx_q.size() == 0) begin
                break;
            end
            cyc();
        end
        dev_tx_ready = 1'b0;
        checks++;
        if (tx_q.size() != 0 || dev_tx_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s_done: left %0d words valid=%b, expected 0 words valid=0", name, tx_q.size(), dev_tx_valid);
            tx_q.delete();
        end
    endtask

    // Drain RX through cpu_in_re, comparing each consumed word.
    task automatic drain_rx(input string name);
        for (int i = 0; i < 4 * D + 4; i++) begin
            if (!cpu_in_avail) break;
            checks++;
            if (rx_q.size() == 0) begin
                fails++;
                $display("FAIL %s_extra: got word %0d, expected no word", name, cpu_datain);
            end else begin
                exp_w = rx_q.pop_front();
                if (cpu_datain !== exp_w) begin
                    fails++;
                    $display("FAIL %s_data: got %0d expected %0d", name, cpu_datain, exp_w);
                end
            end
            cpu_in_re = 1'b1;
            cyc();
            cpu_in_re = 1'b0;
        end
        checks++;
        if (rx_q.size() != 0 || cpu_in_avail !== 1'b0) begin
            fails++;
            $display("FAIL %s_done: left %0d words avail=%b, expected 0 words avail=0", name, rx_q.size(), cpu_in_avail);
            rx_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        #2;
        checks++;
        if ({dev_tx_valid, cpu_in_avail, cpu_out_full, dev_rx_ready, ovf_sticky, udf_sticky} !== 6'b000100) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 000100",
                     {dev_tx_valid, cpu_in_avail, cpu_out_full, dev_rx_ready, ovf_sticky, udf_sticky});
        end
        checks++;
        if (dev_tx_data !== '0 || cpu_datain !== '0) begin
            fails++;
            $display("FAIL reset_data: got tx=%0d in=%0d expected 0 0", dev_tx_data, cpu_datain);
        end
        cyc();
        reset_n = 1'b1;
        cyc();
        write_tx(10'd101, 1'b0);
        write_tx(10'd102, 1'b0);
        write_tx(10'd103, 1'b0);
        checks++;
        if (dev_tx_valid !== 1'b1 || dev_tx_data !== 10'd101) begin
            fails++;
            $display("FAIL reset_prefill: got valid=%b data=%0d expected 1 101", dev_tx_valid, dev_tx_data);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (dev_tx_valid !== 1'b0 || dev_tx_data !== '0 || dev_rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_async: got valid=%b data=%0d rx_ready=%b expected 0 0 1", dev_tx_valid, dev_tx_data, dev_rx_ready);
        end
        cyc();
        reset_n = 1'b1;
        dev_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (dev_tx_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_stale: got valid=%b data=%0d expected valid 0", dev_tx_valid, dev_tx_data);
            end
        end
        dev_tx_ready = 1'b0;
    endtask

    task automatic test_tx_order();
        write_tx(10'd10, 1'b1);
        write_tx(10'd13, 1'b1);
        write_tx(10'd16, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dev_tx_valid !== 1'b1 || dev_tx_data !== 10'd10) begin
                fails++;
                $display("FAIL tx_hold: got valid=%b data=%0d expected 1 10", dev_tx_valid, dev_tx_data);
            end
            cyc();
        end
        drain_tx("tx_order");
    endtask

    task automatic test_tx_overflow();
        for (int i = 0; i < D; i++) write_tx(10'(20 + i), 1'b1);
        checks++;
        if (cpu_out_full !== 1'b1 || ovf_sticky !== 1'b0) begin
            fails++;
            $display("FAIL ovf_full: got full=%b ovf=%b expected 1 0", cpu_out_full, ovf_sticky);
        end
        write_tx(10'd99, 1'b0);
        checks++;
        if (ovf_sticky !== 1'b1) begin
            fails++;
            $display("FAIL ovf_set: got %b expected 1", ovf_sticky);
        end
        drain_tx("ovf");
        pulse_clr();
        checks++;
        if (ovf_sticky !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clr: got %b expected 0", ovf_sticky);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < D; i++) write_tx(10'(30 + i), 1'b1);
        checks++;
        exp_w = tx_q.pop_front();
        if (dev_tx_data !== exp_w) begin
            fails++;
            $display("FAIL fpp_head: got %0d expected %0d", dev_tx_data, exp_w);
        end
        dev_tx_ready = 1'b1;
        write_tx(10'd55, 1'b1);
        dev_tx_ready = 1'b0;
        checks++;
        if (cpu_out_full !== 1'b1 || ovf_sticky !== 1'b0) begin
            fails++;
            $display("FAIL fpp_full: got full=%b ovf=%b expected 1 0", cpu_out_full, ovf_sticky);
        end
        drain_tx("fpp");
    endtask

    task automatic test_rx();
        send_rx(10'd7);
        checks++;
        if (cpu_in_avail !== 1'b1 || cpu_datain !== 10'd7) begin
            fails++;
            $display("FAIL rx_first: got avail=%b data=%0d expected 1 7", cpu_in_avail, cpu_datain);
        end
        send_rx(10'd8);
        cpu_in_re = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_w = rx_q.pop_front();
            checks++;
            if (cpu_datain !== exp_w) begin
                fails++;
                $display("FAIL rx_data: got %0d expected %0d", cpu_datain, exp_w);
            end
            cyc();
        end
        checks++;
        if (cpu_in_avail !== 1'b0 || cpu_datain !== '0 || udf_sticky !== 1'b0) begin
            fails++;
            $display("FAIL rx_empty: got avail=%b data=%0d udf=%b expected 0 0 0", cpu_in_avail, cpu_datain, udf_sticky);
        end
        cyc();
        cpu_in_re = 1'b0;
        checks++;
        if (udf_sticky !== 1'b1 || cpu_in_avail !== 1'b0) begin
            fails++;
            $display("FAIL rx_udf: got udf=%b avail=%b expected 1 0", udf_sticky, cpu_in_avail);
        end
        pulse_clr();
        checks++;
        if (udf_sticky !== 1'b0) begin
            fails++;
            $display("FAIL udf_clr: got %b expected 0", udf_sticky);
        end
    endtask

    task automatic test_flags_rx_full();
        for (int i = 0; i < D; i++) write_tx(10'(40 + i), 1'b1);
        clr_flags = 1'b1;
        write_tx(10'd77, 1'b0);
        clr_flags = 1'b0;
        checks++;
        if (ovf_sticky !== 1'b0) begin
            fails++;
            $display("FAIL clr_wins: got %b expected 0", ovf_sticky);
        end
        drain_tx("clr");
        for (int i = 0; i < D; i++) send_rx(10'(50 + i));
        checks++;
        if (dev_rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL rx_full_ready: got %b expected 0", dev_rx_ready);
        end
        dev_rx_data  = 10'd60;
        dev_rx_valid = 1'b1;
        exp_w = rx_q.pop_front();
        checks++;
        if (cpu_datain !== exp_w) begin
            fails++;
            $display("FAIL rx_full_head: got %0d expected %0d", cpu_datain, exp_w);
        end
        cyc();
        dev_rx_valid = 1'b0;
        cpu_in_re    = 1'b1;
        cyc();
        cpu_in_re    = 1'b0;
        checks++;
        if (dev_rx_ready !== 1'b1 || ovf_sticky !== 1'b0) begin
            fails++;
            $display("FAIL rx_ready_back: got ready=%b ovf=%b expected 1 0", dev_rx_ready, ovf_sticky);
        end
        drain_rx("rx_full");
    endtask

    task automatic test_back_to_back();
        int tx_cnt = 0;
        int rx_cnt = 0;
        bit tx_pop;
        bit rx_pop;
        for (int i = 0; i < 300; i++) begin
            cpu_out_we   = 1'($urandom_range(0, 1));
            cpu_dataout  = 10'($urandom_range(0, 1023));
            dev_tx_ready = 1'($urandom_range(0, 1));
            dev_rx_valid = 1'($urandom_range(0, 1));
            dev_rx_data  = 10'($urandom_range(0, 1023));
            cpu_in_re    = 1'($urandom_range(0, 1));
            checks++;
            if (dev_tx_valid !== (tx_cnt > 0) || dev_rx_ready !== (rx_cnt < D) || cpu_in_avail !== (rx_cnt > 0)) begin
                fails++;
                $display("FAIL b2b_status: got txv=%b rxr=%b av=%b for tx_cnt=%0d rx_cnt=%0d",
                         dev_tx_valid, dev_rx_ready, cpu_in_avail, tx_cnt, rx_cnt);
            end
            tx_pop = dev_tx_ready && (tx_cnt > 0);
            if (tx_pop) begin
                exp_w = tx_q.pop_front();
                checks++;
                if (dev_tx_data !== exp_w) begin
                    fails++;
                    $display("FAIL b2b_tx: got %0d expected %0d", dev_tx_data, exp_w);
                end
            end
            if (cpu_out_we && (tx_cnt < D || tx_pop)) begin
                tx_q.push_back(cpu_dataout);
                tx_cnt++;
            end
            if (tx_pop) tx_cnt--;
            rx_pop = cpu_in_re && (rx_cnt > 0);
            if (rx_pop) begin
                exp_w = rx_q.pop_front();
                checks++;
                if (cpu_datain !== exp_w) begin
                    fails++;
                    $display("FAIL b2b_rx: got %0d expected %0d", cpu_datain, exp_w);
                end
            end
            if (dev_rx_valid && rx_cnt < D) begin
                rx_q.push_back(dev_rx_data);
                rx_cnt++;
            end
            if (rx_pop) rx_cnt--;
            cyc();
        end
        idle_inputs();
        drain_tx("b2b_tail");
        drain_rx("b2b_tail");
    endtask

    initial begin
        test_reset();
        test_tx_order();
        test_tx_overflow();
        test_full_push_pop();
        test_rx();
        test_flags_rx_full();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
